// File: rtl/scan_chain_engine_if.sv
// ============================================================================
// Module      : scan_chain_engine_if
// Description : Host-side register-file bus of the serial-chain engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface scan_chain_engine_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 3,
  parameter int CNT_W  = 9
);
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              start;
  logic              load_en;
  logic              abort;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  mismatch_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, start, load_en, abort,
    input  rd_data, busy, done, mismatch_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, start, load_en, abort,
    output rd_data, busy, done, mismatch_cnt
  );
endinterface

`default_nettype wire

// File: rtl/scan_chain_engine.sv
// ============================================================================
// Module      : scan_chain_engine
// Description : Shifts a word buffer LSB-first into a DUT chain, captures and
//               compares the chain output, with an optional load strobe.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module scan_chain_engine #(
  parameter int DATA_W    = 32,
  parameter int CHAIN_LEN = 256,
  parameter int CLK_DIV   = 4,
  parameter int AW        = (CHAIN_LEN / DATA_W > 1) ? $clog2(CHAIN_LEN / DATA_W) : 1,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  wire logic            S_AXI_ACLK,
  input  wire logic            S_AXI_ARESETN,
  scan_chain_engine_if.slave   bus,
  output logic                 chain_clk,
  output logic                 chain_in,
  output logic                 chain_load,
  input  wire logic            chain_out
);

  localparam int c_ph_w  = $clog2(2 * CLK_DIV);
  localparam int c_idx_w = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int c_bit_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int c_words = CHAIN_LEN / DATA_W;

  localparam logic [c_ph_w-1:0]  c_half_ph  = c_ph_w'(CLK_DIV - 1);
  localparam logic [c_ph_w-1:0]  c_last_ph  = c_ph_w'(2 * CLK_DIV - 1);
  localparam logic [c_idx_w-1:0] c_last_bit = c_idx_w'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]   c_cnt_max  = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t               r_state, w_state_n;
  logic [c_ph_w-1:0]    r_phase, w_phase_n;
  logic [c_idx_w-1:0]   r_bit_idx, w_bit_idx_n;
  logic                 r_load_en, w_load_en_n;
  logic                 w_clk_n, w_in_n, w_load_n;
  logic                 r_busy, w_busy_n;
  logic                 r_done, w_done_n;
  logic [CNT_W-1:0]     r_mismatch;
  logic [DATA_W-1:0]    r_rd_data;
  logic [1:0]           r_sync;

  logic [DATA_W-1:0]    r_wbuf [c_words];
  logic [DATA_W-1:0]    r_rbuf [c_words];

  logic [c_idx_w-1:0]   w_idx_inc;
  logic [AW-1:0]        w_cur_word, w_nxt_word;
  logic [c_bit_w-1:0]   w_cur_bit, w_nxt_bit;
  logic                 w_cur_wbit, w_nxt_wbit, w_bit0;
  logic                 w_capture, w_wr_ok;

  assign w_idx_inc  = (r_bit_idx == c_last_bit) ? '0 : r_bit_idx + 1'b1;
  assign w_cur_word = AW'(32'(r_bit_idx) / DATA_W);
  assign w_cur_bit  = c_bit_w'(32'(r_bit_idx) % DATA_W);
  assign w_nxt_word = AW'(32'(w_idx_inc) / DATA_W);
  assign w_nxt_bit  = c_bit_w'(32'(w_idx_inc) % DATA_W);
  assign w_cur_wbit = r_wbuf[w_cur_word][w_cur_bit];
  assign w_nxt_wbit = r_wbuf[w_nxt_word][w_nxt_bit];
  assign w_bit0     = r_wbuf[0][0];

  // Sample the chain output on the last high cycle of each bit.
  assign w_capture = (r_state == SHIFT) && (r_phase == c_last_ph) && !bus.abort;
  // Writes are refused from the start cycle onward so bit 0 and the rest agree.
  assign w_wr_ok   = ((r_state == IDLE) && !bus.start) || (r_state == FIN);

  always_comb begin
    w_state_n   = r_state;
    w_phase_n   = r_phase;
    w_bit_idx_n = r_bit_idx;
    w_load_en_n = r_load_en;
    w_clk_n     = chain_clk;
    w_in_n      = chain_in;
    w_load_n    = chain_load;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_n   = SHIFT;
          w_phase_n   = '0;
          w_bit_idx_n = '0;
          w_load_en_n = bus.load_en;
          w_clk_n     = 1'b0;
          w_in_n      = w_bit0;
          w_load_n    = 1'b0;
          w_busy_n    = 1'b1;
        end
      end
      SHIFT: begin
        if (r_phase == c_last_ph) begin
          w_phase_n = '0;
          w_clk_n   = 1'b0;
          if (r_bit_idx == c_last_bit) begin
            w_in_n = 1'b0;
            if (r_load_en) begin
              w_state_n = LOAD;
              w_load_n  = 1'b1;
            end else begin
              w_state_n = FIN;
              w_busy_n  = 1'b0;
              w_done_n  = 1'b1;
            end
          end else begin
            w_bit_idx_n = w_idx_inc;
            w_in_n      = w_nxt_wbit;
          end
        end else begin
          w_phase_n = r_phase + 1'b1;
          if (r_phase == c_half_ph) begin
            w_clk_n = 1'b1;
          end
        end
      end
      LOAD: begin
        if (r_phase == c_last_ph) begin
          w_state_n = FIN;
          w_phase_n = '0;
          w_load_n  = 1'b0;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end else begin
          w_phase_n = r_phase + 1'b1;
        end
      end
      FIN: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase

    if ((r_state != IDLE) && bus.abort) begin
      w_state_n = IDLE;
      w_phase_n = '0;
      w_clk_n   = 1'b0;
      w_in_n    = 1'b0;
      w_load_n  = 1'b0;
      w_busy_n  = 1'b0;
      w_done_n  = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_bit_idx  <= '0;
      r_load_en  <= 1'b0;
      chain_clk  <= 1'b0;
      chain_in   <= 1'b0;
      chain_load <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= '0;
      r_rd_data  <= '0;
      r_sync     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_phase    <= w_phase_n;
      r_bit_idx  <= w_bit_idx_n;
      r_load_en  <= w_load_en_n;
      chain_clk  <= w_clk_n;
      chain_in   <= w_in_n;
      chain_load <= w_load_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_rd_data  <= r_rbuf[bus.rd_addr];
      r_sync     <= {r_sync[0], chain_out};
      if ((r_state == IDLE) && bus.start) begin
        r_mismatch <= '0;
      end else if (w_capture && (r_sync[1] != w_cur_wbit) && (r_mismatch != c_cnt_max)) begin
        r_mismatch <= r_mismatch + 1'b1;
      end
    end
  end

  // Buffers are plain storage and deliberately carry no reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_wr_ok && bus.wr_en) begin
      r_wbuf[bus.wr_addr] <= bus.wr_data;
    end
    if (w_capture) begin
      r_rbuf[w_cur_word][w_cur_bit] <= r_sync[1];
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.mismatch_cnt = r_mismatch;
  assign bus.rd_data      = r_rd_data;

endmodule

`default_nettype wire

// File: doc/scan_chain_engine.md
Name: scan_chain_engine

Overview:
Parametrised serial-chain engine for DUT configuration and scan chains. It replaces fixed software bit-banging of config_clk/config_in/config_load and scan_in/scan_load with a hardware sequencer. A word-addressed write buffer is shifted LSB-first into the DUT while the chain output is captured into a readback buffer and compared bit-by-bit against the write buffer, with an optional load strobe. Sits between the AXI register file and the DUT pins, and is instantiated once per chain (config, scan).

Parameters:
DATA_W, 32, buffer word width (matches AXI data width)
CHAIN_LEN, 256, chain length in bits; must be a multiple of DATA_W
CLK_DIV, 4, chain_clk half-period in S_AXI_ACLK cycles; minimum 3
AW, $clog2(CHAIN_LEN/DATA_W), buffer word address width (min 1)
CNT_W, $clog2(CHAIN_LEN+1), mismatch counter width

Ports:
S_AXI_ACLK  in  1  single clock for all logic
S_AXI_ARESETN  in  1  asynchronous active-low reset
wr_en  in  1  write wr_data to write buffer word wr_addr
wr_addr  in  AW  write buffer word address
wr_data  in  DATA_W  write data
rd_addr  in  AW  readback buffer word address
rd_data  out  DATA_W  readback word, registered
start  in  1  one-cycle pulse starts an operation
load_en  in  1  sampled at start; 1 = append load strobe
abort  in  1  terminate the current operation
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
mismatch_cnt  out  CNT_W  count of captured bits that differ from the write buffer
chain_clk  out  1  DUT chain clock
chain_in  out  1  DUT chain serial data in
chain_load  out  1  DUT load strobe
chain_out  in  1  DUT chain serial out, asynchronous; 2-FF synchronised internally

Behaviour:
- Reset values: chain_clk, chain_in, chain_load, busy and done are 0; mismatch_cnt is 0; rd_data is 0; bit index and phase counters are 0. Buffer contents are not reset.
- FSM states: IDLE, SHIFT, LOAD, FIN.
- IDLE: a start pulse, sampled at cycle 0, loads load_en, clears mismatch_cnt and enters SHIFT. busy rises at cycle 1.
- SHIFT, per bit i (i = 0..CHAIN_LEN-1):
  - Bit order: bit i = write buffer word i/DATA_W, bit i%DATA_W.
  - Low phase: chain_clk is low for CLK_DIV cycles, and chain_in is set to bit i on the first low cycle.
  - High phase: chain_clk is high for CLK_DIV cycles. On the last high cycle, the synchronised chain_out is written to readback bit i.
  - Compare: if the captured bit differs from write bit i, mismatch_cnt increments on that cycle.
  - Bit 0 is presented at cycle 1. Each bit takes 2*CLK_DIV cycles.
- After bit CHAIN_LEN-1: go to LOAD if the latched load_en is 1, else go to FIN.
- LOAD: chain_in = 0, chain_clk = 0, chain_load = 1 for 2*CLK_DIV cycles, then go to FIN.
- FIN: done = 1 and busy = 0 in the same cycle, then return to IDLE.
- Latency, start to done: 2*CLK_DIV*CHAIN_LEN + (load_en ? 2*CLK_DIV : 0) + 1 cycles.
- start while busy is ignored. wr_en while busy is ignored, so the write buffer is frozen during an operation.
- rd_data is valid one cycle after rd_addr. Readback is allowed at any time; words being captured show partial data.
- abort: in any non-IDLE state, abort takes priority over all other transitions. The next cycle is IDLE with busy = 0, chain_clk = 0, chain_in = 0 and chain_load = 0. done is not pulsed. mismatch_cnt holds its partial count.
- start and abort in the same cycle while in IDLE: start wins.
- mismatch_cnt saturates at CHAIN_LEN; it cannot wrap.
- chain_clk and chain_load are driven straight from flops, so they are glitch-free.

Test Plan:
1. Reset, using CHAIN_LEN=64, DATA_W=32, CLK_DIV=4 for all tests: assert S_AXI_ARESETN=0 asynchronously -> all outputs 0 immediately, with no clock edge required.
2. Shift only: write word0 = 0xA5A50F0F and word1 = 0x12345678, tie chain_out = 0, start with load_en = 0 -> exactly 64 chain_clk rising edges, chain_in sequence 1,1,1,1,0,0,0,0,... (word0 LSB first), chain_load never asserted, done at cycle 513, mismatch_cnt = 29, readback words both 0x00000000.
3. Loopback with load: bench models chain_out as a 64-bit shift register clocked by chain_clk. Run pass 1 as in test 2, then pass 2 with the same data and load_en = 1 -> readback = 0xA5A50F0F / 0x12345678, mismatch_cnt = 0, chain_load high for exactly 8 cycles after the last falling edge, done at cycle 521.
4. Abort: pulse abort during bit 10 -> next cycle busy = 0 and chain_clk = chain_in = 0, done never pulses, mismatch_cnt holds its partial value; a following start completes normally.
5. Protection: while busy, pulse start, and write 0xFFFFFFFF to word0 -> no restart, and the shifted chain_in sequence and the post-operation buffer both still reflect 0xA5A50F0F.
6. Reset mid-operation: deassert S_AXI_ARESETN at bit 30 -> outputs return to reset values at once; after release, busy stays 0 until the next start.
